processing_unit: RTL and testbench
==================================

// Module: processing_unit
// PURPOSE
// - One processing unit (PU) of the DRL accelerator: a 64-lane signed 8-bit dot-product engine.
// - Holds a local weight memory (wmem), a 32-entry partial-sum cache, bias add, ReLU and a result memory (rmem).
// - The array controller streams activations in and sequences weights, accumulation, cache and result writes.
// PARAMETERS
// - DATA_WIDTH 8: signed activation/weight width.
// - NUM_MAC4 16: number of 4-lane MAC groups (64 lanes).
// - WADDR_WIDTH 7: wmem address width (128 rows x 512 b).
// - RADDR_WIDTH 6: rmem depth = 2^RADDR_WIDTH words (address bit 6 ignored).
// - Derived: TOTAL_INPUT_WIDTH = NUM_MAC4*4*DATA_WIDTH (512); TOTAL_OUTPUT_WIDTH = 2*DATA_WIDTH+6 (22).
// PORTS
// - clk  in 1  system clock
// - rst_n  in 1  asynchronous active-low reset
// - in_mac_en  in 1  issue one dot-product op this cycle
// - in_data  in 512  activations; lane i = [8i+:8], signed
// - in_add_bias / in_relu / in_done  in 1 each  add bias / apply ReLU on final op / final partial sum
// - in_cache_clear  in 1  active-low synchronous clear of the whole cache
// - in_cache_wr_en  in 1; in_cache_rd_addr, in_cache_wr_addr  in 5  partial-sum cache control
// - in_w_wr_en  in 1; in_w_wr_addr  in 7; in_w_wr_data  in 512  wmem write port
// - in_w_rd_addr  in 7  weight row for this op; in_bias_addr  in 3  bias select
// - in_r_wr_en  in 1; in_r_wr_addr  in 7; in_r_rd_en  in 1; in_r_rd_addr  in 7  rmem ports
// - out_total_sum  out 22 signed  op result; out_rmem  out 22 signed  rmem read data
// BEHAVIOUR
// - Reset: all pipeline registers, valid bits, out_total_sum, out_rmem and cache entries are 0. wmem/rmem are not reset.
// - Op issue, cycle T: in_mac_en=1 samples in_data, in_w_rd_addr and all op controls (add_bias, relu, done, cache rd/wr addr, cache_wr_en, bias_addr).
//   These values travel with the op through the pipeline.
// - Edge end of T: wmem row read (synchronous) and in_data registered.
// - Edge end of T+1: the 64 signed 8x8 products and adder tree are registered (22-bit tree sum, no overflow possible).
// - Edge end of T+2: total = tree + cache[rd_addr] + (add_bias ? bias : 0).
//   - out_total_sum <= (done && relu && total<0) ? 0 : total.
//   - If cache_wr_en, cache[wr_addr] <= total (pre-ReLU).
//   - Latency is 3 edges; throughput is 1 op/cycle.
// - Arithmetic is 22-bit two's complement and wraps on overflow (no saturation).
// - bias = signed field wmem[127][64*in_bias_addr +: 22], read in the op's T+1 stage.
// - in_mac_en=0: no op enters; out_total_sum holds; no cache write.
// - Cache: a read and write to the same address at one edge reads the old value.
//   in_cache_clear=0 zeroes all entries at the edge and takes priority over an op write.
// - wmem: write at the edge when in_w_wr_en=1; a same-address read in the same cycle returns old data.
// - rmem write: in_r_wr_en=1 stores the current out_total_sum at rmem[in_r_wr_addr[5:0]] at the edge.
// - rmem read: in_r_rd_en=1 loads out_rmem <= rmem[in_r_rd_addr[5:0]] at the edge, read-before-write.
//   in_r_rd_en=0: out_rmem holds.
// - Reset asserted mid-op flushes the pipeline; the partial op produces no output or cache write.
// STRUCTURE
// - Shared package pu_pkg: DATA_WIDTH, lane count, OUT_W=22, CACHE_DEPTH=32, BIAS_ROW=127.
// - One sub-module, mac_array: registered 64-lane multiply plus adder tree.
// - Top-level logic: wmem, cache, rmem and accumulate/bias/ReLU stage.
// TESTING
// - Reset, then wmem[0]=1 (lane0 weight 1); issue in_data=1, rd_addr 0, cache zero -> out_total_sum=1 three edges later.
// - Lane0 weight -128, data -128, all other lanes 0 -> out_total_sum=16384. All 64 lanes 127x127 -> 1032256.
// - Accumulate: op A (sum 5, cache_wr_en, wr_addr 3), then op B (sum 7, rd_addr 3) -> outputs 5 then 12. Drop in_cache_clear low -> cache[3]=0.
// - Bias/ReLU: wmem[127] field 0 = -10, tree 4.
//   - add_bias=1, done=1, relu=1 -> 0.
//   - Same with relu=0 -> -6 (0x3FFFFA).
// - rmem: out_total_sum=1, write addr 0; next cycle read addr 0 with write addr 1 -> out_rmem=1 and rmem[1]=1.
// - Reset during in-flight op -> outputs 0, no cache update; wmem write/read same address same cycle returns old row.

Source files
------------

// File: rtl/pu_pkg.sv
// Shared constants, op-control record and arithmetic helpers for the DRL processing unit.
package pu_pkg;

    localparam int DATA_WIDTH        = 8;
    localparam int NUM_MAC4          = 16;
    localparam int LANES             = NUM_MAC4 * 4;
    localparam int WADDR_WIDTH       = 7;
    localparam int RADDR_WIDTH       = 6;
    localparam int TOTAL_INPUT_WIDTH = NUM_MAC4 * 4 * DATA_WIDTH;
    localparam int OUT_W             = 2 * DATA_WIDTH + 6;
    localparam int CACHE_DEPTH       = 32;
    localparam int CACHE_AW          = 5;
    localparam int BIAS_AW           = 3;
    localparam int WMEM_DEPTH        = 2 ** WADDR_WIDTH;
    localparam int RMEM_DEPTH        = 2 ** RADDR_WIDTH;
    localparam int BIAS_ROW          = 127;

    typedef logic signed [OUT_W-1:0] acc_t;

    // Controls sampled at issue and carried alongside the op.
    typedef struct packed {
        logic                add_bias;
        logic                relu;
        logic                done;
        logic                cache_wr_en;
        logic [CACHE_AW-1:0] cache_rd_addr;
        logic [CACHE_AW-1:0] cache_wr_addr;
        logic [BIAS_AW-1:0]  bias_addr;
    } op_ctrl_t;

    function automatic acc_t mul_sext(input logic signed [DATA_WIDTH-1:0] a,
                                      input logic signed [DATA_WIDTH-1:0] b);
        logic signed [2*DATA_WIDTH-1:0] p;
        p = a * b;
        return {{(OUT_W-2*DATA_WIDTH){p[2*DATA_WIDTH-1]}}, p};
    endfunction

endpackage

// File: rtl/processing_unit_if.sv
// Bus between the array controller (master) and one processing unit (slave).
interface processing_unit_if;
    import pu_pkg::*;

    logic                         in_mac_en;
    logic [TOTAL_INPUT_WIDTH-1:0] in_data;
    logic                         in_add_bias;
    logic                         in_relu;
    logic                         in_done;
    logic                         in_cache_clear;
    logic                         in_cache_wr_en;
    logic [CACHE_AW-1:0]          in_cache_rd_addr;
    logic [CACHE_AW-1:0]          in_cache_wr_addr;
    logic                         in_w_wr_en;
    logic [WADDR_WIDTH-1:0]       in_w_wr_addr;
    logic [TOTAL_INPUT_WIDTH-1:0] in_w_wr_data;
    logic [WADDR_WIDTH-1:0]       in_w_rd_addr;
    logic [BIAS_AW-1:0]           in_bias_addr;
    logic                         in_r_wr_en;
    logic [WADDR_WIDTH-1:0]       in_r_wr_addr;
    logic                         in_r_rd_en;
    logic [WADDR_WIDTH-1:0]       in_r_rd_addr;
    logic signed [OUT_W-1:0]      out_total_sum;
    logic signed [OUT_W-1:0]      out_rmem;

    modport master (
        output in_mac_en, in_data, in_add_bias, in_relu, in_done,
               in_cache_clear, in_cache_wr_en, in_cache_rd_addr, in_cache_wr_addr,
               in_w_wr_en, in_w_wr_addr, in_w_wr_data, in_w_rd_addr, in_bias_addr,
               in_r_wr_en, in_r_wr_addr, in_r_rd_en, in_r_rd_addr,
        input  out_total_sum, out_rmem
    );

    modport slave (
        input  in_mac_en, in_data, in_add_bias, in_relu, in_done,
               in_cache_clear, in_cache_wr_en, in_cache_rd_addr, in_cache_wr_addr,
               in_w_wr_en, in_w_wr_addr, in_w_wr_data, in_w_rd_addr, in_bias_addr,
               in_r_wr_en, in_r_wr_addr, in_r_rd_en, in_r_rd_addr,
        output out_total_sum, out_rmem
    );

endinterface

// File: rtl/processing_unit_mac_array.sv
// Registered 64-lane signed 8x8 multiply with a 22-bit reduction; one pipeline stage.
module mac_array
    import pu_pkg::*;
(
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [TOTAL_INPUT_WIDTH-1:0] act_i,
    input  logic [TOTAL_INPUT_WIDTH-1:0] wgt_i,
    output acc_t                         sum_o
);

    acc_t group_d [NUM_MAC4];
    acc_t sum_d;
    acc_t sum_q;

    // Four-lane partial products per MAC4 group, then the groups are summed.
    always_comb begin
        sum_d = '0;
        for (int g = 0; g < NUM_MAC4; g++) begin
            group_d[g] = '0;
            for (int l = 0; l < 4; l++) begin
                group_d[g] = group_d[g]
                           + mul_sext(act_i[DATA_WIDTH*(4*g+l) +: DATA_WIDTH],
                                      wgt_i[DATA_WIDTH*(4*g+l) +: DATA_WIDTH]);
            end
            sum_d = sum_d + group_d[g];
        end
    end

    // Tree-sum register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_q <= '0;
        end else begin
            sum_q <= sum_d;
        end
    end

    assign sum_o = sum_q;

endmodule

// File: rtl/processing_unit.sv
// One DRL processing unit: weight memory, 3-stage dot-product pipeline with
// partial-sum cache, bias add and ReLU, plus a result memory.
module processing_unit
    import pu_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    processing_unit_if.slave   bus
);

    logic [TOTAL_INPUT_WIDTH-1:0] wmem_q [WMEM_DEPTH];
    acc_t                         rmem_q [RMEM_DEPTH];
    acc_t                         cache_q [CACHE_DEPTH];

    logic [TOTAL_INPUT_WIDTH-1:0] act_q;
    logic [TOTAL_INPUT_WIDTH-1:0] wrow_q;
    op_ctrl_t                     ctrl1_q;
    op_ctrl_t                     ctrl2_q;
    op_ctrl_t                     ctrl_d;
    logic                         vld1_q;
    logic                         vld2_q;
    acc_t                         bias_q;
    acc_t                         bias_d;
    acc_t                         tree_s;
    acc_t                         total_d;
    acc_t                         result_d;
    acc_t                         out_total_sum_q;
    acc_t                         out_rmem_q;
    logic                         unused_addr_s;

    assign unused_addr_s = bus.in_r_wr_addr[WADDR_WIDTH-1] ^ bus.in_r_rd_addr[WADDR_WIDTH-1];

    assign ctrl_d = '{add_bias:      bus.in_add_bias,
                      relu:          bus.in_relu,
                      done:          bus.in_done,
                      cache_wr_en:   bus.in_cache_wr_en,
                      cache_rd_addr: bus.in_cache_rd_addr,
                      cache_wr_addr: bus.in_cache_wr_addr,
                      bias_addr:     bus.in_bias_addr};

    // Weight memory write port; no reset.
    always_ff @(posedge clk) begin
        if (bus.in_w_wr_en) begin
            wmem_q[bus.in_w_wr_addr] <= bus.in_w_wr_data;
        end
    end

    // Stage 1: synchronous weight-row read, activation and control capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            act_q   <= '0;
            wrow_q  <= '0;
            ctrl1_q <= '0;
            vld1_q  <= 1'b0;
        end else begin
            vld1_q <= bus.in_mac_en;
            if (bus.in_mac_en) begin
                act_q   <= bus.in_data;
                wrow_q  <= wmem_q[bus.in_w_rd_addr];
                ctrl1_q <= ctrl_d;
            end else begin
                act_q   <= act_q;
                wrow_q  <= wrow_q;
                ctrl1_q <= ctrl1_q;
            end
        end
    end

    mac_array u_mac_array (
        .clk   (clk),
        .rst_n (rst_n),
        .act_i (act_q),
        .wgt_i (wrow_q),
        .sum_o (tree_s)
    );

    // Bias lives in the last weight row, one 22-bit field per 64-bit slot.
    assign bias_d = wmem_q[BIAS_ROW][{ctrl1_q.bias_addr, 6'd0} +: OUT_W];

    // Stage 2: controls and bias travel alongside the tree register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ctrl2_q <= '0;
            vld2_q  <= 1'b0;
            bias_q  <= '0;
        end else begin
            ctrl2_q <= ctrl1_q;
            vld2_q  <= vld1_q;
            bias_q  <= bias_d;
        end
    end

    // Stage 3 arithmetic: wraps in 22 bits; ReLU only on the final partial sum.
    always_comb begin
        total_d = tree_s + cache_q[ctrl2_q.cache_rd_addr];
        if (ctrl2_q.add_bias) begin
            total_d = total_d + bias_q;
        end else begin
            total_d = total_d;
        end
        if (ctrl2_q.done && ctrl2_q.relu && total_d[OUT_W-1]) begin
            result_d = '0;
        end else begin
            result_d = total_d;
        end
    end

    // Stage 3 output register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_total_sum_q <= '0;
        end else if (vld2_q) begin
            out_total_sum_q <= result_d;
        end else begin
            out_total_sum_q <= out_total_sum_q;
        end
    end

    // Partial-sum cache: active-low clear beats an op write; stores pre-ReLU total.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < CACHE_DEPTH; i++) begin
                cache_q[i] <= '0;
            end
        end else if (!bus.in_cache_clear) begin
            for (int i = 0; i < CACHE_DEPTH; i++) begin
                cache_q[i] <= '0;
            end
        end else if (vld2_q && ctrl2_q.cache_wr_en) begin
            cache_q[ctrl2_q.cache_wr_addr] <= total_d;
        end else begin
            cache_q <= cache_q;
        end
    end

    // Result memory write port; no reset.
    always_ff @(posedge clk) begin
        if (bus.in_r_wr_en) begin
            rmem_q[bus.in_r_wr_addr[RADDR_WIDTH-1:0]] <= out_total_sum_q;
        end
    end

    // Result memory read register (read-before-write).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_rmem_q <= '0;
        end else if (bus.in_r_rd_en) begin
            out_rmem_q <= rmem_q[bus.in_r_rd_addr[RADDR_WIDTH-1:0]];
        end else begin
            out_rmem_q <= out_rmem_q;
        end
    end

    assign bus.out_total_sum = out_total_sum_q;
    assign bus.out_rmem      = out_rmem_q;

endmodule

// File: tb/tb_processing_unit.sv
// Directed, table-driven bench for processing_unit with hand-computed results.
module tb_processing_unit;
    import pu_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    processing_unit_if bus ();

    processing_unit dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        string             name;
        logic signed [7:0] w0;
        logic signed [7:0] wr;
        logic signed [7:0] d0;
        logic signed [7:0] dr;
        logic [21:0]       exp;
    } vec_t;

    vec_t vecs [6];

    task automatic check(input string name, input logic [21:0] act, input logic [21:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%h) expected %0d (0x%h)",
                     name, $signed(act), act, $signed(exp), exp);
        end
    endtask

    function automatic logic [511:0] mk_row(input logic [7:0] l0, input logic [7:0] rest);
        logic [511:0] r;
        r = {LANES{rest}};
        r[7:0] = l0;
        return r;
    endfunction

    task automatic idle_inputs();
        bus.in_mac_en        = 1'b0;
        bus.in_data          = '0;
        bus.in_add_bias      = 1'b0;
        bus.in_relu          = 1'b0;
        bus.in_done          = 1'b0;
        bus.in_cache_clear   = 1'b1;
        bus.in_cache_wr_en   = 1'b0;
        bus.in_cache_rd_addr = 5'd0;
        bus.in_cache_wr_addr = 5'd0;
        bus.in_w_wr_en       = 1'b0;
        bus.in_w_wr_addr     = 7'd0;
        bus.in_w_wr_data     = '0;
        bus.in_w_rd_addr     = 7'd0;
        bus.in_bias_addr     = 3'd0;
        bus.in_r_wr_en       = 1'b0;
        bus.in_r_wr_addr     = 7'd0;
        bus.in_r_rd_en       = 1'b0;
        bus.in_r_rd_addr     = 7'd0;
    endtask

    task automatic wmem_write(input logic [6:0] addr, input logic [511:0] row);
        bus.in_w_wr_en   = 1'b1;
        bus.in_w_wr_addr = addr;
        bus.in_w_wr_data = row;
        @(negedge clk);
        bus.in_w_wr_en   = 1'b0;
    endtask

    // Sets up one op for the coming edge (does not advance time).
    task automatic set_op(input logic [6:0] wrow, input logic [511:0] data,
                          input logic ab, input logic relu, input logic done,
                          input logic cwe, input logic [4:0] crd, input logic [4:0] cwr,
                          input logic [2:0] baddr);
        bus.in_mac_en        = 1'b1;
        bus.in_w_rd_addr     = wrow;
        bus.in_data          = data;
        bus.in_add_bias      = ab;
        bus.in_relu          = relu;
        bus.in_done          = done;
        bus.in_cache_wr_en   = cwe;
        bus.in_cache_rd_addr = crd;
        bus.in_cache_wr_addr = cwr;
        bus.in_bias_addr     = baddr;
    endtask

    // Single op, returns at the negedge after its third edge.
    task automatic run_op(input logic [6:0] wrow, input logic [511:0] data,
                          input logic ab, input logic relu, input logic done,
                          input logic cwe, input logic [4:0] crd, input logic [4:0] cwr,
                          input logic [2:0] baddr);
        set_op(wrow, data, ab, relu, done, cwe, crd, cwr, baddr);
        @(negedge clk);
        bus.in_mac_en      = 1'b0;
        bus.in_cache_wr_en = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    logic [511:0] one_s;
    logic [511:0] zero_s;
    logic [511:0] brow;

    initial begin
        vecs[0] = '{"unit",      8'sd1,    8'sd0,    8'sd1,    8'sd0,   22'd1};
        vecs[1] = '{"neg_min",  -8'sd128,  8'sd0,   -8'sd128,  8'sd0,   22'd16384};
        vecs[2] = '{"all_max",   8'sd127,  8'sd127,  8'sd127,  8'sd127, 22'd1032256};
        vecs[3] = '{"mixed",     8'sd3,   -8'sd1,    8'sd5,    8'sd2,  -22'sd111};
        vecs[4] = '{"most_neg", -8'sd128, -8'sd128,  8'sd127,  8'sd127, -22'sd1040384};
        vecs[5] = '{"zero_w",    8'sd0,    8'sd0,    8'sd100, -8'sd5,   22'd0};
        one_s  = mk_row(8'd1, 8'd0);
        zero_s = '0;

        idle_inputs();
        repeat (2) @(negedge clk);
        check("reset_total", bus.out_total_sum, 22'd0);
        check("reset_rmem",  bus.out_rmem,      22'd0);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 6; i++) begin
            wmem_write(7'd0, mk_row(vecs[i].w0, vecs[i].wr));
            run_op(7'd0, mk_row(vecs[i].d0, vecs[i].dr), 1'b0, 1'b0, 1'b0,
                   1'b0, 5'd0, 5'd0, 3'd0);
            check(vecs[i].name, bus.out_total_sum, vecs[i].exp);
        end

        // Accumulate through cache entry 3, back-to-back ops.
        wmem_write(7'd1, mk_row(8'd5, 8'd0));
        wmem_write(7'd2, mk_row(8'd7, 8'd0));
        set_op(7'd1, one_s, 1'b0, 1'b0, 1'b0, 1'b1, 5'd0, 5'd3, 3'd0);
        @(negedge clk);
        set_op(7'd2, one_s, 1'b0, 1'b0, 1'b0, 1'b0, 5'd3, 5'd0, 3'd0);
        @(negedge clk);
        bus.in_mac_en = 1'b0;
        @(negedge clk);
        check("acc_a", bus.out_total_sum, 22'd5);
        @(negedge clk);
        check("acc_b", bus.out_total_sum, 22'd12);
        @(negedge clk);
        check("hold_idle", bus.out_total_sum, 22'd12);
        bus.in_cache_clear = 1'b0;
        @(negedge clk);
        bus.in_cache_clear = 1'b1;
        run_op(7'd1, zero_s, 1'b0, 1'b0, 1'b0, 1'b0, 5'd3, 5'd0, 3'd0);
        check("cache_clear", bus.out_total_sum, 22'd0);

        // Bias / ReLU: field0=-10, field1=100, tree 4.
        brow = '0;
        brow[21:0]   = 22'h3FFFF6;
        brow[64+:22] = 22'd100;
        wmem_write(7'd127, brow);
        wmem_write(7'd4, mk_row(8'd4, 8'd0));
        run_op(7'd4, one_s, 1'b1, 1'b1, 1'b1, 1'b1, 5'd0, 5'd5, 3'd0);
        check("relu_clamp", bus.out_total_sum, 22'd0);
        run_op(7'd4, one_s, 1'b1, 1'b0, 1'b1, 1'b0, 5'd0, 5'd0, 3'd0);
        check("bias_norelu", bus.out_total_sum, 22'h3FFFFA);
        run_op(7'd4, one_s, 1'b1, 1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 3'd0);
        check("relu_not_done", bus.out_total_sum, 22'h3FFFFA);
        run_op(7'd4, zero_s, 1'b0, 1'b0, 1'b0, 1'b0, 5'd5, 5'd0, 3'd0);
        check("cache_pre_relu", bus.out_total_sum, 22'h3FFFFA);
        run_op(7'd4, one_s, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 3'd1);
        check("bias_field1", bus.out_total_sum, 22'd104);

        // wmem same-address write/read returns the old row.
        wmem_write(7'd9, mk_row(8'd2, 8'd0));
        bus.in_w_wr_en   = 1'b1;
        bus.in_w_wr_addr = 7'd9;
        bus.in_w_wr_data = mk_row(8'd50, 8'd0);
        run_op(7'd9, one_s, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 3'd0);
        bus.in_w_wr_en = 1'b0;
        check("wmem_rbw_old", bus.out_total_sum, 22'd2);
        run_op(7'd9, one_s, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 3'd0);
        check("wmem_new", bus.out_total_sum, 22'd50);

        // rmem write/read, read-before-write, address bit 6 ignored, hold.
        wmem_write(7'd8, one_s);
        run_op(7'd8, one_s, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 3'd0);
        bus.in_r_wr_en = 1'b1; bus.in_r_wr_addr = 7'd0;
        @(negedge clk);
        bus.in_r_wr_addr = 7'd1; bus.in_r_rd_en = 1'b1; bus.in_r_rd_addr = 7'd0;
        @(negedge clk);
        bus.in_r_wr_en = 1'b0; bus.in_r_rd_en = 1'b0;
        check("rmem_rd0", bus.out_rmem, 22'd1);
        run_op(7'd9, one_s, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 3'd0);
        bus.in_r_wr_en = 1'b1; bus.in_r_wr_addr = 7'd1;
        bus.in_r_rd_en = 1'b1; bus.in_r_rd_addr = 7'd1;
        @(negedge clk);
        bus.in_r_wr_en = 1'b0;
        check("rmem_rbw_old", bus.out_rmem, 22'd1);
        bus.in_r_rd_addr = 7'd65;
        @(negedge clk);
        check("rmem_addr_wrap", bus.out_rmem, 22'd50);
        bus.in_r_rd_en = 1'b0; bus.in_r_rd_addr = 7'd0;
        @(negedge clk);
        check("rmem_hold", bus.out_rmem, 22'd50);

        // Reset with an op in flight: no output, no cache write.
        set_op(7'd9, one_s, 1'b0, 1'b0, 1'b0, 1'b1, 5'd0, 5'd7, 3'd0);
        @(negedge clk);
        bus.in_mac_en = 1'b0; bus.in_cache_wr_en = 1'b0;
        rst_n = 1'b0;
        #1;
        check("rst_async", bus.out_total_sum, 22'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_flush", bus.out_total_sum, 22'd0);
        run_op(7'd9, zero_s, 1'b0, 1'b0, 1'b0, 1'b0, 5'd7, 5'd0, 3'd0);
        check("rst_no_cache", bus.out_total_sum, 22'd0);
        run_op(7'd9, one_s, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 3'd0);
        check("post_rst_op", bus.out_total_sum, 22'd50);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
